// File: rtl/ieee488_dev_engine_if.sv
// IEEE-488 bus pin bundle between the device engine and the bus I/O pads.
// All levels are bus levels: active-low, 1 = released.
//   slave  : device side (engine) - samples *_i, drives *_o
//   master : pad / bus-model side - drives *_i, samples *_o
interface ieee488_dev_engine_if;
    logic [7:0] bus_data_i;
    logic [7:0] bus_data_o;
    logic       atn_i;
    logic       ifc_i;
    logic       eoi_i;
    logic       dav_i;
    logic       nrfd_i;
    logic       ndac_i;
    logic       eoi_o;
    logic       dav_o;
    logic       nrfd_o;
    logic       ndac_o;

    modport slave (
        input  bus_data_i, atn_i, ifc_i, eoi_i, dav_i, nrfd_i, ndac_i,
        output bus_data_o, eoi_o, dav_o, nrfd_o, ndac_o
    );

    modport master (
        output bus_data_i, atn_i, ifc_i, eoi_i, dav_i, nrfd_i, ndac_i,
        input  bus_data_o, eoi_o, dav_o, nrfd_o, ndac_o
    );
endinterface

// File: rtl/ieee488_dev_engine.sv
// IEEE-488 device-side bus engine: three-wire handshake for listener and
// talker, hardware ATN trap, addressing command decode, RX/TX byte FIFOs.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   ce                bus-timing enable; FSMs sample/advance only when 1
//   my_addr, dev_en   primary address; 0 = ignore bus, release everything
//   bus               IEEE-488 pins (slave modport)
//   rx_*              RX FIFO head (zero-latency) and pop strobe
//   tx_*              TX FIFO push side
//   listening/talking addressed state
//   sec_addr/valid    last secondary address for this device + 1-clk pulse
//   rx_ovf            sticky RX push-into-full flag (cleared by reset/IFC)
module ieee488_dev_engine #(
    parameter int DEPTH_LOG2 = 4,
    parameter int SETTLE     = 3,
    parameter int RX_FLAGS   = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ce,
    input  logic [4:0]                  my_addr,
    input  logic                        dev_en,
    ieee488_dev_engine_if.slave         bus,
    output logic [7:0]                  rx_data,
    output logic                        rx_eoi,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_eoi,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        listening,
    output logic                        talking,
    output logic [4:0]                  sec_addr,
    output logic                        sec_valid,
    output logic                        rx_ovf
);
    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic       eoi;
        logic [7:0] data;
    } ent_t;

    typedef enum logic [1:0] {L_WAIT, L_RDY, L_ACC, L_DONE} l_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SETTLE, T_WNRFD, T_WNDAC} t_state_t;

    l_state_t   l_st, l_nx;
    t_state_t   t_st, t_nx;
    logic [7:0] settle_cnt;
    logic [7:0] lat_data;
    logic       lat_eoi, lat_cmd;
    logic       addressed;  // last primary command named this device

    logic en, l_active, t_active;
    logic l_latch, l_push, l_decode, l_nrfd_low, l_ndac_low;
    logic t_pop, t_drive, t_dav_low, cnt_clr, cnt_inc;

    // FIFO 0 = RX, 1 = TX
    ent_t [1:0] f_wdata, f_rdata;
    logic [1:0] f_push, f_pop, f_empty, f_full;

    assign en       = dev_en & bus.ifc_i;
    // Under ATN every device takes part in the command handshake.
    assign l_active = en & (~bus.atn_i | listening);
    // ATN low kills the talker combinationally (abort in the same cycle).
    assign t_active = en & talking & bus.atn_i;

    // ---------------- FIFOs ----------------
    assign f_wdata[0] = '{eoi: (RX_FLAGS != 0) & lat_eoi, data: lat_data};
    assign f_push[0]  = l_push;
    assign f_pop[0]   = rx_ready;
    assign f_wdata[1] = '{eoi: tx_eoi, data: tx_data};
    assign f_push[1]  = tx_valid;
    assign f_pop[1]   = t_pop;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        ent_t       mem [DEPTH];
        logic [AW:0] wptr, rptr;
        logic       do_push, do_pop;

        assign f_empty[g] = (wptr == rptr);
        assign f_full[g]  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        assign do_pop     = f_pop[g] & ~f_empty[g];
        // A pop in the same cycle frees the slot, so push into full succeeds.
        assign do_push    = f_push[g] & (~f_full[g] | do_pop);
        assign f_rdata[g] = mem[rptr[AW-1:0]];

        always_ff @(posedge clk) begin
            if (do_push && en)
                mem[wptr[AW-1:0]] <= f_wdata[g];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wptr <= '0;
                rptr <= '0;
            end else if (!en) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
                if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    assign rx_data  = f_rdata[0].data;
    assign rx_eoi   = f_rdata[0].eoi;
    assign rx_valid = ~f_empty[0];
    assign tx_ready = ~f_full[1];

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        l_nx       = l_st;
        l_latch    = 1'b0;
        l_push     = 1'b0;
        l_decode   = 1'b0;
        l_nrfd_low = 1'b0;
        l_ndac_low = 1'b0;
        if (!l_active) begin
            l_nx = L_WAIT;
        end else begin
            unique case (l_st)
                L_WAIT: begin
                    l_nrfd_low = 1'b1;
                    l_ndac_low = 1'b1;
                    // RX full holds NRFD low: flow control, not overflow.
                    if (ce && (!bus.atn_i || !f_full[0])) l_nx = L_RDY;
                end
                L_RDY: begin
                    l_ndac_low = 1'b1;
                    if (ce && !bus.dav_i) begin
                        l_latch = 1'b1;
                        l_nx    = L_ACC;
                    end
                end
                L_ACC: begin
                    l_nrfd_low = 1'b1;
                    if (ce) begin
                        l_decode = lat_cmd;
                        l_push   = ~lat_cmd;
                        l_nx     = L_DONE;
                    end
                end
                L_DONE: begin
                    l_nrfd_low = 1'b1;
                    if (ce && bus.dav_i) l_nx = L_WAIT;
                end
                default: l_nx = L_WAIT;
            endcase
        end

        t_nx      = t_st;
        t_pop     = 1'b0;
        t_drive   = 1'b0;
        t_dav_low = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        if (!t_active) begin
            t_nx = T_IDLE;  // abort: head stays in TX FIFO
        end else begin
            unique case (t_st)
                T_IDLE: begin
                    if (ce && !f_empty[1]) begin
                        cnt_clr = 1'b1;
                        t_nx    = T_SETTLE;
                    end
                end
                T_SETTLE: begin
                    t_drive = 1'b1;
                    if (ce) begin
                        if (settle_cnt == 8'(SETTLE - 1)) t_nx = T_WNRFD;
                        else                              cnt_inc = 1'b1;
                    end
                end
                T_WNRFD: begin
                    t_drive = 1'b1;
                    // NRFD and NDAC both high means nobody is listening: keep waiting.
                    if (ce && bus.nrfd_i && !bus.ndac_i) t_nx = T_WNDAC;
                end
                T_WNDAC: begin
                    t_drive   = 1'b1;
                    t_dav_low = 1'b1;
                    if (ce && bus.ndac_i) begin
                        t_pop = 1'b1;
                        t_nx  = T_IDLE;
                    end
                end
                default: t_nx = T_IDLE;
            endcase
        end
    end

    assign bus.bus_data_o = (t_active & t_drive) ? ~f_rdata[1].data : 8'hFF;
    assign bus.eoi_o      = ~(t_active & t_drive & f_rdata[1].eoi);
    assign bus.dav_o      = ~(t_active & t_dav_low);
    assign bus.nrfd_o     = ~(l_active & l_nrfd_low);
    assign bus.ndac_o     = ~(l_active & l_ndac_low);

    // ---------------- state and datapath registers ----------------
    logic [6:0] cmd7;
    logic       cmd_listen_me, cmd_talk_me;
    assign cmd7          = lat_data[6:0];
    assign cmd_listen_me = (cmd7 == {2'b01, my_addr});
    assign cmd_talk_me   = (cmd7 == {2'b10, my_addr});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_st       <= L_WAIT;
            t_st       <= T_IDLE;
            settle_cnt <= '0;
            lat_data   <= '0;
            lat_eoi    <= 1'b0;
            lat_cmd    <= 1'b0;
            addressed  <= 1'b0;
            listening  <= 1'b0;
            talking    <= 1'b0;
            sec_addr   <= '0;
            sec_valid  <= 1'b0;
            rx_ovf     <= 1'b0;
        end else begin
            l_st      <= l_nx;
            t_st      <= t_nx;
            sec_valid <= 1'b0;

            if (cnt_clr)      settle_cnt <= '0;
            else if (cnt_inc) settle_cnt <= settle_cnt + 8'd1;

            if (!bus.ifc_i)
                rx_ovf <= 1'b0;
            else if (l_push && f_full[0] && !(f_pop[0] && !f_empty[0]))
                rx_ovf <= 1'b1;

            if (l_latch) begin
                lat_data <= ~bus.bus_data_i;
                lat_eoi  <= ~bus.eoi_i;
                lat_cmd  <= ~bus.atn_i;
            end

            if (!en) begin
                listening <= 1'b0;
                talking   <= 1'b0;
                sec_addr  <= '0;
                addressed <= 1'b0;
            end else if (l_decode) begin
                // Unlisten/untalk first so address 31 cannot shadow them.
                if (cmd7 == 7'h3F) begin
                    listening <= 1'b0;
                    addressed <= 1'b0;
                end else if (cmd_listen_me) begin
                    listening <= 1'b1;
                    talking   <= 1'b0;
                    addressed <= 1'b1;
                end else if (cmd7 == 7'h5F) begin
                    talking   <= 1'b0;
                    addressed <= 1'b0;
                end else if (cmd_talk_me) begin
                    talking   <= 1'b1;
                    listening <= 1'b0;
                    addressed <= 1'b1;
                end else if (cmd7[6:5] == 2'b10) begin
                    talking   <= 1'b0;  // another device became talker
                    addressed <= 1'b0;
                end else if (cmd7[6:5] == 2'b01) begin
                    addressed <= 1'b0;
                end else if (cmd7[6:5] == 2'b11 && addressed) begin
                    sec_addr  <= cmd7[4:0];
                    sec_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/ieee488_dev_engine.md
Name: ieee488_dev_engine

Overview:
Parametrised hardware IEEE-488 device-side bus engine. It is the successor to the firmware-driven VIA bit-banging used in the 2031-style drive logic. It performs the three-wire handshake (DAV/NRFD/NDAC) for both listener and talker roles, applies the ATN trap in hardware, and decodes addressing commands (LISTEN/UNLISTEN/TALK/UNTALK/secondary). Data is exchanged with the drive CPU side through parametrised RX/TX FIFOs. It sits between the bus I/O pins and the drive's CPU-visible registers.

Parameters:
DEPTH_LOG2, 4, log2 of RX and TX FIFO depth (depth 16 by default).
SETTLE, 3, ce ticks between data/EOI driven and DAV asserted (talker).
RX_FLAGS, 1, 1 = RX entries carry an EOI bit; 0 = the stored EOI bit is forced to 0.

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
ce  in  1  bus-timing enable; all bus sampling and state advance happen only on ce=1
my_addr  in  5  primary address (0..30)
dev_en  in  1  0 = device ignores the bus; all bus outputs released
bus_data_i  in  8  bus DIO levels (low = logic 1)
bus_data_o  out  8  DIO drive (1 = released)
atn_i, ifc_i, eoi_i, dav_i, nrfd_i, ndac_i  in  1 each  bus levels, active-low, already synchronised
eoi_o, dav_o, nrfd_o, ndac_o  out  1 each  bus drive, active-low (1 = released)
rx_data  out  8  FIFO head data byte (logic polarity)
rx_eoi  out  1  FIFO head EOI flag
rx_valid  out  1  FIFO not empty
rx_ready  in  1  pop strobe; pops when rx_valid & rx_ready
tx_data  in  8  byte to send
tx_eoi  in  1  send this byte with EOI
tx_valid  in  1  push strobe
tx_ready  out  1  TX FIFO not full
listening  out  1  addressed as listener
talking  out  1  addressed as talker
sec_addr  out  5  last secondary address received for this device
sec_valid  out  1  one-clk pulse when sec_addr updates
rx_ovf  out  1  sticky; set on a push attempt into a full RX FIFO; cleared by reset or IFC

Behaviour:
- Reset / ifc_i=0 / dev_en=0:
  - All bus outputs = 1.
  - listening = talking = 0; sec_addr = 0; sec_valid = 0; rx_ovf = 0 (ifc_i and reset only).
  - Both FIFOs flushed; FSM goes to IDLE.
  - ifc_i and dev_en act synchronously; reset_n acts asynchronously.
- ATN trap (combinational, as on the real hardware):
  - While atn_i=0, ndac_o is forced low until the command byte handshake runs, and dav_o, eoi_o and bus_data_o are released.
  - When atn_i falls, any talker transfer aborts the same cycle; the TX FIFO head is not popped.
- Listener FSM (data phase requires listening=1, atn_i=1; command phase under atn_i=0 always runs):
  - L_WAIT: nrfd_o=0, ndac_o=0. Go to L_RDY when RX is not full (data) or unconditionally (command).
  - L_RDY: nrfd_o=1. On dav_i=0, latch ~bus_data_i and ~eoi_i, then go to L_ACC.
  - L_ACC: nrfd_o=0, ndac_o=1 (release). Push the latched byte (data), or decode it (command).
  - L_DONE: wait for dav_i=1, set ndac_o=0, return to L_WAIT.
  - Data phase with RX full stays in L_WAIT, so NRFD is held low as flow control. Overflow cannot occur in normal operation; rx_ovf only guards the case of a simultaneous pop and external full.
- Command decode (7 LSBs of the byte):
  - 0x20+my_addr: listening=1, talking=0.
  - 0x3F: listening=0.
  - 0x40+my_addr: talking=1, listening=0.
  - 0x40+other address: talking=0.
  - 0x5F: talking=0.
  - 0x60..0x7F, only if the preceding primary command addressed this device: sec_addr=byte[4:0], sec_valid pulses.
  - Other bytes are ignored.
- Talker FSM (talking=1, atn_i=1):
  - T_IDLE: when TX is not empty, drive the byte and EOI, then go to T_SETTLE.
  - T_SETTLE: count SETTLE ce ticks, then go to T_WNRFD.
  - T_WNRFD: wait for nrfd_i=1 and ndac_i=0, then set dav_o=0 and go to T_WNDAC.
  - T_WNDAC: wait for ndac_i=1, then set dav_o=1, pop TX, release data/EOI, return to T_IDLE.
  - If nrfd_i=1 and ndac_i=1 both hold in T_WNRFD (no listeners), remain waiting. No timeout.
- FIFOs:
  - Synchronous, wrapping pointers of DEPTH_LOG2+1 bits. Full when MSBs differ and LSBs are equal.
  - Push and pop in the same cycle are both allowed. With rx full, a simultaneous push and pop succeeds.
  - rx_data / rx_eoi show the head combinationally (zero-latency read).
- Latency: bus sampling is 1 ce tick per state, so the minimum listener byte time is 4 ce ticks after dav_i falls.

Test Plan:
- Reset: hold reset_n=0 mid-transfer (talker in T_WNDAC) -> all *_o=1, bus_data_o=0xFF, tx_ready=1, rx_valid=0 within 0 clk.
- Command: my_addr=8; ATN low, send 0x28 then 0x6F -> listening=1, sec_addr=0x0F, one sec_valid pulse; send 0x3F -> listening=0.
- Listen: after LISTEN 8, send 0x41 then 0x42 with EOI -> RX holds {0x41, eoi=0}, {0x42, eoi=1}; NRFD/NDAC sequence is correct per byte.
- Flow control: fill RX with 16 bytes without popping -> nrfd_o stays 0 on the 17th DAV attempt; pop one -> 17th accepted; rx_ovf=0.
- Talk: TALK 8 (0x48), push 0x55 with tx_eoi=1 -> bus_data_o=0xAA and eoi_o=0 for SETTLE ticks before dav_o=0; after ndac_i=1, dav_o=1 and TX empty.
- ATN abort: ATN falls while in T_WNDAC -> dav_o, eoi_o and data released, ndac_o=0 the same cycle; TX still holds 0x55; UNTALK 0x5F -> talking=0.
